// File: rtl/d_cache_pkg.sv
// Shared geometry, FSM state type and address-field helpers for the direct-mapped data cache.
package d_cache_pkg;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INDEX_W  = 6;
  localparam int unsigned OFFSET_W = 3;
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = ADDR_W - OFFSET_W;
  localparam int unsigned SETS     = 1 << INDEX_W;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLookup,
    StWb,
    StWbWait,
    StRf,
    StRfWait,
    StFill
  } state_e;

  // Helpers take a line (doubleword) address, i.e. the byte address without its offset bits.
  function automatic logic [TAG_W-1:0] line_tag(input logic [LINE_W-1:0] line);
    return line[LINE_W-1 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] line_index(input logic [LINE_W-1:0] line);
    return line[INDEX_W-1:0];
  endfunction

endpackage

// File: rtl/d_cache_wmerge.sv
// Byte-enable merge of store data into a 64-bit cache line.
module d_cache_wmerge (
  input  logic [63:0] line_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wmask_i,
  output logic [63:0] line_o
);

  always_comb begin
    line_o = line_i;
    for (int b = 0; b < 8; b++) begin
      if (wmask_i[b]) begin
        line_o[8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/d_cache_ctrl.sv
// Direct-mapped L1 data-cache controller: tag compare, write-back/refill FSM, dirty bits and
// the post-reset valid-clear sweep of the (unreset) tag RAM.
module d_cache_ctrl
  import d_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [63:0]         req_wdata,
  input  logic [7:0]          req_wmask,
  output logic                resp_valid,
  output logic [63:0]         resp_rdata,
  output logic [INDEX_W-1:0]  tag_addr_o,
  output logic [TAG_W:0]      tag_wdata_o,
  output logic                tag_we_o,
  input  logic [TAG_W-1:0]    tag_data_i,
  input  logic                tag_valid_i,
  output logic [INDEX_W-1:0]  dat_addr_o,
  output logic                dat_we_o,
  output logic [7:0]          dat_wmask_o,
  output logic [63:0]         dat_wdata_o,
  input  logic [63:0]         dat_rdata_i,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [63:0]         mem_req_wdata,
  input  logic                mem_resp_valid,
  input  logic [63:0]         mem_resp_rdata
);

  state_e              state_q, state_d;
  logic [INDEX_W-1:0]  cnt_q, cnt_d;
  logic [SETS-1:0]     dirty_q, dirty_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                we_q, we_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          wmask_q, wmask_d;
  logic [LINE_W-1:0]   victim_q, victim_d;
  logic [63:0]         vdata_q, vdata_d;
  logic [63:0]         fill_q, fill_d;

  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic [63:0]         merge_base;
  logic [7:0]          merge_mask;
  logic [63:0]         merged;
  logic                unused_req_offset;

  assign idx = line_index(line_q);
  assign tag = line_tag(line_q);
  assign hit = tag_valid_i && (tag_data_i == tag);
  assign unused_req_offset = ^req_addr[OFFSET_W-1:0];

  // Store hits merge into the line just read; fills merge into refill data only for stores.
  assign merge_base = (state_q == StFill) ? fill_q : dat_rdata_i;
  assign merge_mask = (state_q == StFill && !we_q) ? 8'h00 : wmask_q;

  d_cache_wmerge u_wmerge (
    .line_i  (merge_base),
    .wdata_i (wdata_q),
    .wmask_i (merge_mask),
    .line_o  (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StInit;
      cnt_q    <= '0;
      dirty_q  <= '0;
      line_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      victim_q <= '0;
      vdata_q  <= '0;
      fill_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dirty_q  <= dirty_d;
      line_q   <= line_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      victim_q <= victim_d;
      vdata_q  <= vdata_d;
      fill_q   <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:   if (cnt_q == INDEX_W'(SETS - 1)) state_d = StIdle;
      StIdle:   if (req_valid) state_d = StLookup;
      StLookup: begin
        if (hit)                              state_d = StIdle;
        else if (tag_valid_i && dirty_q[idx]) state_d = StWb;
        else                                  state_d = StRf;
      end
      StWb:     if (mem_req_ready) state_d = StWbWait;
      StWbWait: if (mem_resp_valid) state_d = StRf;
      StRf:     if (mem_req_ready) state_d = StRfWait;
      StRfWait: if (mem_resp_valid) state_d = StFill;
      StFill:   state_d = StIdle;
      default:  state_d = StInit;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    dirty_d  = dirty_q;
    line_d   = line_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    victim_d = victim_q;
    vdata_d  = vdata_q;
    fill_d   = fill_q;
    case (state_q)
      StInit: cnt_d = cnt_q + 1'b1;
      StIdle: begin
        if (req_valid) begin
          line_d  = req_addr[ADDR_W-1:OFFSET_W];
          we_d    = req_we;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
        end
      end
      StLookup: begin
        if (hit) begin
          if (we_q) dirty_d[idx] = 1'b1;
        end else if (tag_valid_i && dirty_q[idx]) begin
          victim_d = {tag_data_i, idx};
          vdata_d  = dat_rdata_i;
        end
      end
      StWbWait: if (mem_resp_valid) dirty_d[idx] = 1'b0;
      StRfWait: if (mem_resp_valid) fill_d = mem_resp_rdata;
      StFill:   dirty_d[idx] = we_q;
      default: ;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    tag_addr_o    = idx;
    tag_wdata_o   = '0;
    tag_we_o      = 1'b0;
    dat_addr_o    = idx;
    dat_we_o      = 1'b0;
    dat_wmask_o   = '0;
    dat_wdata_o   = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    unique case (state_q)
      StInit: begin
        tag_addr_o = cnt_q;
        // Keep the sweep write quiet while reset is held so every output idles at 0.
        tag_we_o   = rst;
      end
      StIdle: begin
        req_ready  = 1'b1;
        tag_addr_o = line_index(req_addr[ADDR_W-1:OFFSET_W]);
        dat_addr_o = line_index(req_addr[ADDR_W-1:OFFSET_W]);
      end
      StLookup: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_rdata = dat_rdata_i;
          if (we_q) begin
            dat_we_o    = 1'b1;
            dat_wmask_o = wmask_q;
            dat_wdata_o = merged;
          end
        end
      end
      StWb: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {victim_q, {OFFSET_W{1'b0}}};
        mem_req_wdata = vdata_q;
      end
      StRf: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {line_q, {OFFSET_W{1'b0}}};
      end
      StFill: begin
        tag_we_o    = 1'b1;
        tag_wdata_o = {1'b1, tag};
        dat_we_o    = 1'b1;
        dat_wmask_o = 8'hFF;
        dat_wdata_o = merged;
        resp_valid  = 1'b1;
        resp_rdata  = fill_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Self-checking bench for d_cache_ctrl: RAM and bus models plus a response/bus-request scoreboard.
module tb_d_cache_ctrl;

  typedef struct packed {
    logic        chk;
    logic [63:0] rd;
  } resp_exp_t;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic [5:0]  tag_addr_o, dat_addr_o;
  logic [55:0] tag_wdata_o;
  logic        tag_we_o, dat_we_o;
  logic [54:0] tag_rd;
  logic        tag_vrd;
  logic [7:0]  dat_wmask_o;
  logic [63:0] dat_wdata_o, dat_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int resp_seen = 0;
  int last_resp_cyc = 0;
  int mem_hs = 0;
  int stall_seen = 0;
  int stall_chg = 0;
  int stall_until = 0;
  int resp_lat = 3;
  logic [63:0] stall_addr = '0;

  resp_exp_t exp_resp[$];
  mem_exp_t  exp_mem[$];
  logic [63:0] bus_mem[logic [63:0]];
  logic [55:0] tram[64];
  logic [63:0] dram[64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  d_cache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_we         (req_we),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .tag_addr_o     (tag_addr_o),
    .tag_wdata_o    (tag_wdata_o),
    .tag_we_o       (tag_we_o),
    .tag_data_i     (tag_rd),
    .tag_valid_i    (tag_vrd),
    .dat_addr_o     (dat_addr_o),
    .dat_we_o       (dat_we_o),
    .dat_wmask_o    (dat_wmask_o),
    .dat_wdata_o    (dat_wdata_o),
    .dat_rdata_i    (dat_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  // Registered-read tag and data RAMs (read-first).
  always @(posedge clk) begin
    if (tag_we_o) tram[tag_addr_o] <= tag_wdata_o;
    {tag_vrd, tag_rd} <= tram[tag_addr_o];
    if (dat_we_o) begin
      for (int b = 0; b < 8; b++) begin
        if (dat_wmask_o[b]) dram[dat_addr_o][8*b +: 8] <= dat_wdata_o[8*b +: 8];
      end
    end
    dat_rd <= dram[dat_addr_o];
  end

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    mem_exp_t m;
    m.we = we;
    m.addr = addr;
    m.wdata = wdata;
    exp_mem.push_back(m);
  endtask

  // Response checker and bus responder; bus inputs change on the falling edge.
  initial begin : monitor
    int pend;
    logic [63:0] pdata;
    resp_exp_t re;
    mem_exp_t me;
    pend = 0;
    pdata = '0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        resp_seen++;
        last_resp_cyc = cyc;
        if (exp_resp.size() == 0) begin
          check_eq("resp_unexpected", 64'(exp_resp.size()), 64'd1);
        end else begin
          re = exp_resp.pop_front();
          if (re.chk) check_eq("resp_rdata", resp_rdata, re.rd);
        end
      end
      mem_resp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_rdata = pdata;
        end
      end
      mem_req_ready = (cyc >= stall_until);
      if (mem_req_valid && !mem_req_ready) begin
        if (stall_seen > 0 && mem_req_addr != stall_addr) stall_chg++;
        stall_addr = mem_req_addr;
        stall_seen++;
      end
      if (mem_req_valid && mem_req_ready) begin
        mem_hs++;
        if (exp_mem.size() == 0) begin
          check_eq("mem_unexpected", 64'(exp_mem.size()), 64'd1);
        end else begin
          me = exp_mem.pop_front();
          check_eq("mem_we", 64'(mem_req_we), 64'(me.we));
          check_eq("mem_addr", mem_req_addr, me.addr);
          if (me.we) check_eq("mem_wdata", mem_req_wdata, me.wdata);
        end
        if (mem_req_we) begin
          bus_mem[mem_req_addr] = mem_req_wdata;
          pdata = '0;
        end else begin
          pdata = bus_mem.exists(mem_req_addr) ? bus_mem[mem_req_addr] : 64'd0;
        end
        pend = resp_lat;
      end
    end
  end

  task automatic init_sweep();
    int good;
    int early;
    good = 0;
    early = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (tag_we_o && tag_addr_o == 6'(i) && tag_wdata_o == '0) good++;
      if (req_ready) early++;
      @(negedge clk);
    end
    #1;
    check_eq("init_writes", 64'(good), 64'd64);
    check_eq("init_ready_early", 64'(early), 64'd0);
    check_eq("ready_cycle65", 64'(req_ready), 64'd1);
    check_eq("init_tag_we_end", 64'(tag_we_o), 64'd0);
  endtask

  task automatic do_req(input logic [63:0] a, input logic we, input logic [63:0] wd,
                        input logic [7:0] wm, input logic chk, input logic [63:0] exp_rd,
                        output int lat);
    resp_exp_t r;
    int start;
    int n;
    int acc;
    r.chk = chk;
    r.rd = exp_rd;
    exp_resp.push_back(r);
    start = resp_seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = a;
    req_we = we;
    req_wdata = wd;
    req_wmask = wm;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    req_we = 1'b0;
    n = 0;
    while (resp_seen == start && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("resp_count", 64'(resp_seen - start), 64'd1);
    lat = last_resp_cyc - acc;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int hs0;
    int n;
    rst = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_we = 1'b0;
    req_wdata = '0;
    req_wmask = '0;
    bus_mem[64'h1000] = 64'hDEADBEEF_CAFEF00D;
    bus_mem[64'h2000] = 64'h01234567_89ABCDEF;
    bus_mem[64'h3000] = 64'h33333333_33333333;
    bus_mem[64'h4000] = 64'h44444444_44444444;
    bus_mem[64'h5008] = 64'h55555555_55555555;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ctrl_outs", 64'({req_ready, resp_valid, tag_we_o, dat_we_o, mem_req_valid,
                                   mem_req_we}), 64'd0);
    check_eq("rst_tag_addr", 64'(tag_addr_o), 64'd0);
    check_eq("rst_mem_addr", mem_req_addr, 64'd0);
    init_sweep();

    // Cold load, then a hit on the same line.
    push_mem(1'b0, 64'h1000, '0);
    do_req(64'h1000, 1'b0, '0, '0, 1'b1, 64'hDEADBEEF_CAFEF00D, lat);
    check_eq("fill_tag", 64'(tram[0]), {8'd0, 1'b1, 55'h8});
    check_eq("fill_data", dram[0], 64'hDEADBEEF_CAFEF00D);
    hs0 = mem_hs;
    do_req(64'h1000, 1'b0, '0, '0, 1'b1, 64'hDEADBEEF_CAFEF00D, lat);
    check_eq("hit_latency", 64'(lat), 64'd0);
    check_eq("hit_no_bus", 64'(mem_hs - hs0), 64'd0);

    // Store hit, then read it back.
    do_req(64'h1000, 1'b1, 64'h11, 8'h01, 1'b0, '0, lat);
    check_eq("store_hit_data", dram[0], 64'hDEADBEEF_CAFEF011);
    check_eq("store_hit_dirty", 64'(dut.dirty_q[0]), 64'd1);
    check_eq("store_hit_no_bus", 64'(mem_hs - hs0), 64'd0);
    do_req(64'h1000, 1'b0, '0, '0, 1'b1, 64'hDEADBEEF_CAFEF011, lat);

    // Conflict miss on a dirty line: write-back then refill.
    push_mem(1'b1, 64'h1000, 64'hDEADBEEF_CAFEF011);
    push_mem(1'b0, 64'h2000, '0);
    do_req(64'h2000, 1'b0, '0, '0, 1'b1, 64'h01234567_89ABCDEF, lat);
    check_eq("wb_dirty_clear", 64'(dut.dirty_q[0]), 64'd0);
    check_eq("wb_new_tag", 64'(tram[0]), {8'd0, 1'b1, 55'h10});

    // Refill request held off by the bus.
    push_mem(1'b0, 64'h3000, '0);
    stall_until = cyc + 12;
    do_req(64'h3000, 1'b0, '0, '0, 1'b1, 64'h33333333_33333333, lat);
    check_eq("stall_held", 64'(stall_seen >= 8), 64'd1);
    check_eq("stall_addr_stable", 64'(stall_chg), 64'd0);
    check_eq("stall_addr", stall_addr, 64'h3000);

    do_req(64'h3000, 1'b1, 64'hAB00, 8'h02, 1'b0, '0, lat);

    // Store miss: response carries raw refill data, the line gets the merged bytes.
    push_mem(1'b0, 64'h5008, '0);
    do_req(64'h5008, 1'b1, 64'h77000000_00000000, 8'h80, 1'b1, 64'h55555555_55555555, lat);
    check_eq("store_miss_line", dram[1], 64'h77555555_55555555);
    check_eq("store_miss_dirty", 64'(dut.dirty_q[1]), 64'd1);
    do_req(64'h5008, 1'b0, '0, '0, 1'b1, 64'h77555555_55555555, lat);

    // Reset while the refill response is still outstanding.
    hs0 = mem_hs;
    push_mem(1'b1, 64'h3000, 64'h33333333_3333AB33);
    push_mem(1'b0, 64'h4000, '0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 64'h4000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (mem_hs - hs0 < 1 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    resp_lat = 25;
    n = 0;
    while (mem_hs - hs0 < 2 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    check_eq("rf_reached", 64'(mem_hs - hs0), 64'd2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_ctrl_outs", 64'({req_ready, resp_valid, tag_we_o, dat_we_o, mem_req_valid,
                                      mem_req_we}), 64'd0);
    check_eq("midrst_dirty", dut.dirty_q, 64'd0);
    check_eq("midrst_rdata", resp_rdata, 64'd0);
    init_sweep();
    resp_lat = 3;

    // Every line is invalid again and no write-back of the formerly dirty line occurs.
    push_mem(1'b0, 64'h5008, '0);
    do_req(64'h5008, 1'b0, '0, '0, 1'b1, 64'h55555555_55555555, lat);
    push_mem(1'b0, 64'h4000, '0);
    do_req(64'h4000, 1'b0, '0, '0, 1'b1, 64'h44444444_44444444, lat);

    repeat (5) @(negedge clk);
    check_eq("mem_exp_left", 64'(exp_mem.size()), 64'd0);
    check_eq("resp_exp_left", 64'(exp_resp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
